// File: rtl/shift_ser_ctrl.sv
// shift_ser_ctrl: parallel-load, LSB-first serialiser with a small
// IDLE -> SHIFT -> DONE controller. A word is captured on the edge where
// start is accepted. It is then shifted out one bit per un-held cycle,
// with SI filling from the top. A single done pulse follows the last bit.
module shift_ser_ctrl #(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [N-1:0]  d,
   input  logic          SI,
   input  logic          hold,
   output logic          ready,
   output logic          busy,
   output logic          SO,
   output logic          bit_valid,
   output logic          done,
   output logic [N-1:0]  q,
   output logic [CW-1:0] cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LP_N   = CW'(N);
   localparam logic [CW-1:0] LP_ONE = CW'(1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_q;
   logic [N-1:0]  w_q_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_shift_en;

   // A shift happens only in SHIFT with no stall; it also gates the count.
   assign w_shift_en = (r_state == S_SHIFT) && !hold;

   // State and datapath registers; reset clears everything and wins over start/hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, next-data and Moore/Mealy outputs; the default holds everything.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      ready       = 1'b0;
      busy        = 1'b0;
      SO          = 1'b0;
      bit_valid   = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_state_nxt = S_SHIFT;
               w_q_nxt     = d;
               w_cnt_nxt   = LP_N;
            end
         end
         S_SHIFT: begin
            busy      = 1'b1;
            SO        = r_q[0];
            bit_valid = w_shift_en;
            if (w_shift_en) begin
               w_q_nxt   = {SI, r_q[N-1:1]};
               w_cnt_nxt = r_cnt - LP_ONE;
               // The last bit leaves on this edge, so the next cycle reports done.
               if (r_cnt == LP_ONE) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            // The unused encoding falls back to IDLE.
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign q   = r_q;
   assign cnt = r_cnt;

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Testbench for shift_ser_ctrl (N=4). Inputs change on the falling edge.
// Outputs are sampled 1 ns later, well away from the rising edge.
module tb_shift_ser_ctrl;

   localparam int N  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [N-1:0]  d;
   logic          SI;
   logic          hold;
   logic          ready;
   logic          busy;
   logic          SO;
   logic          bit_valid;
   logic          done;
   logic [N-1:0]  q;
   logic [CW-1:0] cnt;

   int n_pass  = 0;
   int n_total = 0;

   shift_ser_ctrl #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .d(d), .SI(SI), .hold(hold),
      .ready(ready), .busy(busy), .SO(SO), .bit_valid(bit_valid),
      .done(done), .q(q), .cnt(cnt)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Records one transfer. Cycle 0 presents start with dv and releases reset.
   // Later cycles scramble d. They may inject an ignored start in cycle ign_cyc.
   // Hold is raised for hold_len cycles once hold_after bits have been seen.
   task automatic run_xfer(input logic [N-1:0] dv, input logic si, input int hold_after,
                           input int hold_len, input int ign_cyc, input logic [N-1:0] ign_d,
                           output logic [N-1:0] so_bits, output int nv, output int done_at,
                           output int nd, output int ready_at, output int nhold,
                           output logic hold_so, output logic [N+CW+2:0] snap0);
      int  hc;
      bit  seen_done;
      so_bits = '0; nv = 0; done_at = -1; nd = 0; ready_at = -1; nhold = 0;
      hold_so = 1'b0; hc = 0; seen_done = 0;
      @(negedge clk);
      rst = 1'b1; start = 1'b1; d = dv; SI = si; hold = 1'b0;
      #1;
      snap0 = {ready, busy, done, q, cnt};
      for (int c = 1; c < 40 && ready_at < 0; c++) begin
         @(negedge clk);
         start = (c == ign_cyc);
         d     = (c == ign_cyc) ? ign_d : N'($urandom);
         hold  = (nv == hold_after) && (hc < hold_len);
         if (hold) hc++;
         #1;
         if (bit_valid) begin
            if (nv < N) so_bits[nv] = SO;
            nv++;
         end
         if (busy && !done && hold) begin
            nhold++;
            hold_so = hold_so | SO;
         end
         if (done) begin
            nd++;
            done_at   = c;
            seen_done = 1;
         end
         if (ready && seen_done) ready_at = c;
      end
      start = 1'b0; hold = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0; start = 1'b1; d = 4'b1111; SI = 1'b1; hold = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0; hold = 1'b0;
      #1;
      n_total++;
      if ({ready, busy, SO, bit_valid, done} !== 5'b10000) $display("FAIL reset_flags: got %b required 10000", {ready, busy, SO, bit_valid, done});
      else n_pass++;
      n_total++;
      if (q !== 4'b0000) $display("FAIL reset_q: got %b required 0000", q);
      else n_pass++;
      n_total++;
      if (cnt !== 3'd0) $display("FAIL reset_cnt: got %0d required 0", cnt);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [N-1:0] so_bits; int nv, done_at, nd, ready_at, nhold; logic hold_so;
      logic [N+CW+2:0] snap0;
      run_xfer(4'b1011, 1'b0, -1, 0, -1, 4'b0000, so_bits, nv, done_at, nd, ready_at, nhold, hold_so, snap0);
      n_total++;
      if (so_bits !== 4'b1011 || nv != 4) $display("FAIL basic_bits: got %b (%0d valid) required 1011 (4 valid)", so_bits, nv);
      else n_pass++;
      n_total++;
      if (done_at != 5 || nd != 1) $display("FAIL basic_done: got cycle %0d count %0d required cycle 5 count 1", done_at, nd);
      else n_pass++;
      n_total++;
      if (ready_at != 6) $display("FAIL basic_ready: got cycle %0d required 6", ready_at);
      else n_pass++;
      n_total++;
      if (q !== 4'b0000 || cnt !== 3'd0) $display("FAIL basic_final: got q=%b cnt=%0d required q=0000 cnt=0", q, cnt);
      else n_pass++;
   endtask

   task automatic test_hold();
      logic [N-1:0] so_bits; int nv, done_at, nd, ready_at, nhold; logic hold_so;
      logic [N+CW+2:0] snap0;
      run_xfer(4'b1011, 1'b0, 2, 2, -1, 4'b0000, so_bits, nv, done_at, nd, ready_at, nhold, hold_so, snap0);
      n_total++;
      if (so_bits !== 4'b1011 || nv != 4) $display("FAIL hold_bits: got %b (%0d valid) required 1011 (4 valid)", so_bits, nv);
      else n_pass++;
      n_total++;
      if (nhold != 2 || hold_so !== 1'b0) $display("FAIL hold_stall: got %0d stalled cycles SO_or=%b required 2 cycles SO_or=0", nhold, hold_so);
      else n_pass++;
      n_total++;
      if (done_at != 7 || nd != 1 || ready_at != 8) $display("FAIL hold_timing: got done %0d x%0d ready %0d required done 7 x1 ready 8", done_at, nd, ready_at);
      else n_pass++;
   endtask

   task automatic test_ignored_start();
      logic [N-1:0] so_bits; int nv, done_at, nd, ready_at, nhold; logic hold_so;
      logic [N+CW+2:0] snap0;
      run_xfer(4'b1011, 1'b0, -1, 0, 2, 4'b0110, so_bits, nv, done_at, nd, ready_at, nhold, hold_so, snap0);
      n_total++;
      if (so_bits !== 4'b1011 || nv != 4) $display("FAIL ignored_bits: got %b (%0d valid) required 1011 (4 valid)", so_bits, nv);
      else n_pass++;
      n_total++;
      if (nd != 1 || done_at != 5 || ready_at != 6) $display("FAIL ignored_done: got count %0d at %0d ready %0d required 1 at 5 ready 6", nd, done_at, ready_at);
      else n_pass++;
      @(negedge clk);
      start = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || ready !== 1'b1) $display("FAIL ignored_not_queued: got busy=%b ready=%b required busy=0 ready=1", busy, ready);
      else n_pass++;
   endtask

   task automatic test_fill();
      logic [N-1:0] so_bits; int nv, done_at, nd, ready_at, nhold; logic hold_so;
      logic [N+CW+2:0] snap0;
      run_xfer(4'b0000, 1'b1, -1, 0, -1, 4'b0000, so_bits, nv, done_at, nd, ready_at, nhold, hold_so, snap0);
      n_total++;
      if (so_bits !== 4'b0000 || nv != 4) $display("FAIL fill_bits: got %b (%0d valid) required 0000 (4 valid)", so_bits, nv);
      else n_pass++;
      n_total++;
      if (q !== 4'b1111) $display("FAIL fill_q: got %b required 1111", q);
      else n_pass++;
      SI = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] so_bits; int nv, done_at, nd, ready_at, nhold; logic hold_so;
      logic [N+CW+2:0] snap0;
      int nbits, ndone;
      nbits = 0; ndone = 0;
      @(negedge clk);
      start = 1'b1; d = 4'b1011; SI = 1'b0; hold = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst   = (c == 3) ? 1'b0 : 1'b1;
         #1;
         if (c <= 2 && bit_valid) nbits++;
         if (done) ndone++;
      end
      n_total++;
      if (nbits != 2) $display("FAIL midrst_prebits: got %0d required 2", nbits);
      else n_pass++;
      run_xfer(4'b0101, 1'b0, -1, 0, -1, 4'b0000, so_bits, nv, done_at, nd, ready_at, nhold, hold_so, snap0);
      n_total++;
      if (snap0 !== {3'b100, 4'b0000, 3'd0}) $display("FAIL midrst_state: got {ready,busy,done,q,cnt}=%b required 1000000000", snap0);
      else n_pass++;
      n_total++;
      if (ndone != 0) $display("FAIL midrst_nodone: got %0d done pulses required 0", ndone);
      else n_pass++;
      n_total++;
      if (so_bits !== 4'b0101 || nv != 4 || nd != 1) $display("FAIL midrst_restart: got %b (%0d valid, %0d done) required 0101 (4 valid, 1 done)", so_bits, nv, nd);
      else n_pass++;
   endtask

   task automatic test_reset_start();
      @(negedge clk);
      rst = 1'b0; start = 1'b1; d = 4'b1111;
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      #1;
      n_total++;
      if (ready !== 1'b1 || busy !== 1'b0 || q !== 4'b0000) $display("FAIL rststart_idle: got ready=%b busy=%b q=%b required 1 0 0000", ready, busy, q);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (bit_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rststart_noshift: got bit_valid=%b busy=%b required 0 0", bit_valid, busy);
      else n_pass++;
   endtask

   // Random transfers: random d, SI, hold and stray starts, checked against a
   // bit-list model. The word goes out LSB first. Every un-held cycle consumes
   // one bit and records the SI fed in, and those SI values end up in q in arrival order.
   task automatic test_random();
      logic [N-1:0] dv, si_hist;
      int  idx;
      bit  fin;
      for (int t = 0; t < 30; t++) begin
         dv = N'($urandom); si_hist = '0; idx = 0; fin = 0;
         @(negedge clk);
         rst = 1'b1; start = 1'b1; d = dv; SI = 1'($urandom); hold = 1'($urandom);
         #1;
         n_total++;
         if (ready !== 1'b1) $display("FAIL rand_idle_ready t=%0d: got %b required 1", t, ready);
         else n_pass++;
         for (int c = 1; c < 60 && !fin; c++) begin
            @(negedge clk);
            start = 1'($urandom); d = N'($urandom); SI = 1'($urandom);
            hold  = ($urandom_range(0, 3) == 0);
            #1;
            if (idx < N) begin
               n_total++;
               if ({ready, busy, done} !== 3'b010) $display("FAIL rand_shift_flags t=%0d: got %b required 010", t, {ready, busy, done});
               else n_pass++;
               n_total++;
               if (SO !== dv[idx] || bit_valid !== !hold) $display("FAIL rand_bit t=%0d i=%0d: got SO=%b bv=%b required SO=%b bv=%b", t, idx, SO, bit_valid, dv[idx], !hold);
               else n_pass++;
               n_total++;
               if (cnt !== CW'(N - idx)) $display("FAIL rand_cnt t=%0d: got %0d required %0d", t, cnt, N - idx);
               else n_pass++;
               if (!hold) begin
                  si_hist[idx] = SI;
                  idx++;
               end
            end else begin
               n_total++;
               if ({ready, busy, done, bit_valid, SO} !== 5'b01100) $display("FAIL rand_done t=%0d: got %b required 01100", t, {ready, busy, done, bit_valid, SO});
               else n_pass++;
               n_total++;
               if (q !== si_hist) $display("FAIL rand_fill t=%0d: got q=%b required %b", t, q, si_hist);
               else n_pass++;
               fin = 1;
            end
         end
         n_total++;
         if (!fin) $display("FAIL rand_timeout t=%0d: got no done within 60 cycles required done", t);
         else n_pass++;
         @(negedge clk);
         start = 1'b0; hold = 1'($urandom);
         #1;
         n_total++;
         if ({ready, busy, done} !== 3'b100 || q !== si_hist) $display("FAIL rand_back_idle t=%0d: got flags %b q=%b required 100 q=%b", t, {ready, busy, done}, q, si_hist);
         else n_pass++;
      end
      start = 1'b0; hold = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; d = '0; SI = 1'b0; hold = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_ignored_start();
      test_fill();
      test_reset_mid();
      test_reset_start();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
